bcd_time_keeper: RTL and testbench

Parametrised time-of-day core for the VGA clock family. It generates a 1 Hz tick from the pixel clock and keeps hours, minutes and seconds as BCD digits, with full ripple carry in the same cycle. It supports time load, per-field increment (set buttons), run/pause and 12/24-hour display. It sits in the px_clk domain and feeds the digit/font renderer directly.

---
 rtl/bcd_time_keeper_pkg.sv | 66 ++++++
 rtl/bcd_time_keeper_counter.sv | 50 +++++
 rtl/bcd_time_keeper.sv | 168 ++++++++++++++++
 tb/tb_bcd_time_keeper.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_keeper_pkg.sv
// clock_pkg: shared definitions for the BCD time-of-day core.
//   - BCD digit widths for each time field
//   - field limits (59 s, 59 min, 23 h, 12 h noon)
//   - packed 24-bit time record and its bit offsets inside load_time
//   - helpers: BCD-to-binary value, load validation, 12h display mapping
package clock_pkg;

    localparam int unsigned UNIT_W  = 4;
    localparam int unsigned HRS_D_W = 2;
    localparam int unsigned MIN_D_W = 3;
    localparam int unsigned SEC_D_W = 3;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HRS_MAX = 23;
    localparam int unsigned HRS_12  = 12;

    typedef struct packed {
        logic [3:0] hrs_d;
        logic [3:0] hrs_u;
        logic [3:0] min_d;
        logic [3:0] min_u;
        logic [3:0] sec_d;
        logic [3:0] sec_u;
    } bcd_time_t;

    localparam int unsigned HRS_D_LSB = 20;
    localparam int unsigned HRS_U_LSB = 16;
    localparam int unsigned MIN_D_LSB = 12;
    localparam int unsigned MIN_U_LSB = 8;
    localparam int unsigned SEC_D_LSB = 4;
    localparam int unsigned SEC_U_LSB = 0;

    function automatic int unsigned bcd_val(input logic [3:0] d, input logic [3:0] u);
        return 32'(d) * 10 + 32'(u);
    endfunction

    function automatic logic valid_time(input bcd_time_t t);
        logic digits_ok;
        digits_ok = (t.hrs_d <= 4'd9) && (t.hrs_u <= 4'd9) &&
                    (t.min_d <= 4'd9) && (t.min_u <= 4'd9) &&
                    (t.sec_d <= 4'd9) && (t.sec_u <= 4'd9);
        return digits_ok &&
               (bcd_val(t.sec_d, t.sec_u) <= SEC_MAX) &&
               (bcd_val(t.min_d, t.min_u) <= MIN_MAX) &&
               (bcd_val(t.hrs_d, t.hrs_u) <= HRS_MAX);
    endfunction

    // Returns {pm, tens[1:0], units[3:0]} for a 24h BCD hour.
    function automatic logic [6:0] disp_hours(input logic [7:0] h, input logic mode12);
        int unsigned bin;
        int unsigned v;
        logic        pm;
        bin = bcd_val(h[7:4], h[3:0]);
        pm  = (bin >= HRS_12);
        v   = bin;
        if (mode12) begin
            if (bin == 0)
                v = HRS_12;
            else if (bin > HRS_12)
                v = bin - HRS_12;
        end
        return {pm, 2'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_time_keeper_counter.sv
// bcd_mod_counter: two-digit BCD register that wraps to 00 after MAX_D:MAX_U.
//   clk, reset     : clock, async active-high reset to RESET_D:RESET_U
//   inc            : advance by one (units 9 carry into tens)
//   load, load_d/u : parallel load, has priority over inc
//   d, u           : tens / units digits
//   carry          : inc applied while at the maximum (wrap to 00)
module bcd_mod_counter #(
    parameter int unsigned    D_W     = 3,
    parameter logic [D_W-1:0] MAX_D   = D_W'(5),
    parameter logic [3:0]     MAX_U   = 4'd9,
    parameter logic [D_W-1:0] RESET_D = '0,
    parameter logic [3:0]     RESET_U = 4'd0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           load,
    input  logic [D_W-1:0] load_d,
    input  logic [3:0]     load_u,
    output logic [D_W-1:0] d,
    output logic [3:0]     u,
    output logic           carry
);

    logic at_max;

    assign at_max = (d == MAX_D) && (u == MAX_U);
    assign carry  = inc && !load && at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d <= RESET_D;
            u <= RESET_U;
        end else if (load) begin
            d <= load_d;
            u <= load_u;
        end else if (inc) begin
            if (at_max) begin
                d <= '0;
                u <= '0;
            end else if (u == 4'd9) begin
                d <= d + 1'b1;
                u <= '0;
            end else begin
                u <= u + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 1 Hz prescaler plus BCD hh:mm:ss with same-cycle ripple,
// load with validation, set buttons, run/pause and 12h/24h display.
//   clk, reset          : pixel clock, async active-high reset
//   run                 : prescaler enable
//   mode_12h_set        : toggle display mode
//   inc_min, inc_hrs    : set buttons (minutes zero the seconds)
//   load_valid/load_time: load request, {hh,mm,ss} 24h BCD
//   load_ack, load_err  : one-cycle load result
//   hrs_d/hrs_u, pm     : registered display hours
//   min_*, sec_*        : internal minute / second digits
//   mode_12h, sec_pulse : current mode, pulse per applied 1 Hz advance
module bcd_time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 31_500_000,
    parameter logic        MODE_12H_DEFAULT = 1'b0,
    parameter logic [7:0]  RESET_HRS        = 8'h10,
    parameter logic [7:0]  RESET_MIN        = 8'h15,
    parameter logic [7:0]  RESET_SEC        = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mode_12h_set,
    input  logic        inc_min,
    input  logic        inc_hrs,
    input  logic        load_valid,
    input  logic [23:0] load_time,
    output logic        load_ack,
    output logic        load_err,
    output logic [1:0]  hrs_d,
    output logic [3:0]  hrs_u,
    output logic [2:0]  min_d,
    output logic [3:0]  min_u,
    output logic [2:0]  sec_d,
    output logic [3:0]  sec_u,
    output logic        pm,
    output logic        mode_12h,
    output logic        sec_pulse
);

    localparam int unsigned     PS_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_HZ - 1);
    localparam logic [6:0]      RESET_DISP = disp_hours(RESET_HRS, MODE_12H_DEFAULT);

    logic [PS_W-1:0] prescaler;
    logic            tick;
    logic            tick_pending;
    bcd_time_t       ld;
    logic            load_accept;
    logic            load_reject;
    logic            do_inc_min;
    logic            do_inc_hrs;
    logic            free_cycle;
    logic            advance;
    logic            sec_carry;
    logic            min_carry;
    logic            day_wrap_unused;
    logic [1:0]      int_hrs_d;
    logic [3:0]      int_hrs_u;

    assign ld          = load_time;
    assign load_accept = load_valid && valid_time(ld);
    assign load_reject = load_valid && !valid_time(ld);
    assign do_inc_min  = inc_min && !load_valid;
    assign do_inc_hrs  = inc_hrs && !load_valid;
    assign free_cycle  = !load_valid && !inc_min && !inc_hrs;
    assign tick        = run && (prescaler == PS_LAST);
    assign advance     = free_cycle && (tick || tick_pending);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (load_accept) begin
            prescaler <= '0;
        end else if (run) begin
            prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
        end
    end

    // A tick blocked by an inc (or rejected load) is parked for the next free
    // cycle; if a fresh tick lands on that free cycle as well, one is applied
    // and the other stays parked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_pending <= 1'b0;
        end else if (load_accept) begin
            tick_pending <= 1'b0;
        end else if (!free_cycle) begin
            tick_pending <= tick_pending || tick;
        end else begin
            tick_pending <= tick_pending && tick;
        end
    end

    bcd_mod_counter #(
        .D_W     (SEC_D_W),
        .MAX_D   (SEC_D_W'(SEC_MAX / 10)),
        .MAX_U   (4'(SEC_MAX % 10)),
        .RESET_D (RESET_SEC[4 +: SEC_D_W]),
        .RESET_U (RESET_SEC[3:0])
    ) u_sec (
        .clk    (clk),
        .reset  (reset),
        .inc    (advance),
        .load   (load_accept || do_inc_min),
        .load_d (load_accept ? load_time[SEC_D_LSB +: SEC_D_W] : '0),
        .load_u (load_accept ? load_time[SEC_U_LSB +: UNIT_W] : '0),
        .d      (sec_d),
        .u      (sec_u),
        .carry  (sec_carry)
    );

    bcd_mod_counter #(
        .D_W     (MIN_D_W),
        .MAX_D   (MIN_D_W'(MIN_MAX / 10)),
        .MAX_U   (4'(MIN_MAX % 10)),
        .RESET_D (RESET_MIN[4 +: MIN_D_W]),
        .RESET_U (RESET_MIN[3:0])
    ) u_min (
        .clk    (clk),
        .reset  (reset),
        .inc    (do_inc_min || sec_carry),
        .load   (load_accept),
        .load_d (load_time[MIN_D_LSB +: MIN_D_W]),
        .load_u (load_time[MIN_U_LSB +: UNIT_W]),
        .d      (min_d),
        .u      (min_u),
        .carry  (min_carry)
    );

    // Minute wrap from the set button must not reach the hours.
    bcd_mod_counter #(
        .D_W     (HRS_D_W),
        .MAX_D   (HRS_D_W'(HRS_MAX / 10)),
        .MAX_U   (4'(HRS_MAX % 10)),
        .RESET_D (RESET_HRS[4 +: HRS_D_W]),
        .RESET_U (RESET_HRS[3:0])
    ) u_hrs (
        .clk    (clk),
        .reset  (reset),
        .inc    (do_inc_hrs || (min_carry && !do_inc_min)),
        .load   (load_accept),
        .load_d (load_time[HRS_D_LSB +: HRS_D_W]),
        .load_u (load_time[HRS_U_LSB +: UNIT_W]),
        .d      (int_hrs_d),
        .u      (int_hrs_u),
        .carry  (day_wrap_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_12h  <= MODE_12H_DEFAULT;
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            sec_pulse <= 1'b0;
            {pm, hrs_d, hrs_u} <= RESET_DISP;
        end else begin
            if (mode_12h_set)
                mode_12h <= !mode_12h;
            load_ack  <= load_accept;
            load_err  <= load_reject;
            sec_pulse <= advance;
            {pm, hrs_d, hrs_u} <= disp_hours({2'b00, int_hrs_d, int_hrs_u}, mode_12h);
        end
    end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb_bcd_time_keeper: directed bench for bcd_time_keeper with CLK_HZ=10 and
// reset time 23:59:58. Inputs change and outputs are sampled on negedges.
module tb_bcd_time_keeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mode_12h_set;
    logic        inc_min;
    logic        inc_hrs;
    logic        load_valid;
    logic [23:0] load_time;
    logic        load_ack;
    logic        load_err;
    logic [1:0]  hrs_d;
    logic [3:0]  hrs_u;
    logic [2:0]  min_d;
    logic [3:0]  min_u;
    logic [2:0]  sec_d;
    logic [3:0]  sec_u;
    logic        pm;
    logic        mode_12h;
    logic        sec_pulse;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bcd_time_keeper #(
        .CLK_HZ           (10),
        .MODE_12H_DEFAULT (1'b0),
        .RESET_HRS        (8'h23),
        .RESET_MIN        (8'h59),
        .RESET_SEC        (8'h58)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mode_12h_set (mode_12h_set),
        .inc_min      (inc_min),
        .inc_hrs      (inc_hrs),
        .load_valid   (load_valid),
        .load_time    (load_time),
        .load_ack     (load_ack),
        .load_err     (load_err),
        .hrs_d        (hrs_d),
        .hrs_u        (hrs_u),
        .min_d        (min_d),
        .min_u        (min_u),
        .sec_d        (sec_d),
        .sec_u        (sec_u),
        .pm           (pm),
        .mode_12h     (mode_12h),
        .sec_pulse    (sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [23:0] cur_time();
        return {2'b00, hrs_d, hrs_u, 1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
    endfunction

    function automatic logic [15:0] cur_minsec();
        return {1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
    endfunction

    logic [23:0] sw_t  [5] = '{24'h000000, 24'h110000, 24'h120000, 24'h130000, 24'h230000};
    logic [5:0]  sw_h  [5] = '{6'h12, 6'h11, 6'h12, 6'h01, 6'h11};
    logic        sw_pm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [19:0] pulse_mask;
        int unsigned pulses;
        int unsigned waited;

        reset = 1'b1; run = 1'b1; mode_12h_set = 1'b0; inc_min = 1'b0;
        inc_hrs = 1'b0; load_valid = 1'b0; load_time = '0;
        step(2);
        check("reset_time", cur_time(), 24'h235958);
        check("reset_pm", pm, 1'b1);
        check("reset_mode", mode_12h, 1'b0);
        check("reset_ack", load_ack, 1'b0);
        check("reset_err", load_err, 1'b0);
        check("reset_pulse", sec_pulse, 1'b0);
        reset = 1'b0;

        // Free run across midnight: pulse every 10 clocks.
        pulse_mask = '0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            pulse_mask[k-1] = sec_pulse;
            if (k == 10) check("run_5959", cur_minsec(), 16'h5959);
            if (k == 20) check("wrap_minsec", cur_minsec(), 16'h0000);
        end
        check("pulse_spacing", pulse_mask, 20'h80200);
        step(1);
        check("wrap_time", cur_time(), 24'h000000);
        check("wrap_pm", pm, 1'b0);

        // Valid load and the tick that follows.
        load_valid = 1'b1; load_time = 24'h125959;
        step(1);
        load_valid = 1'b0;
        check("load_ack", load_ack, 1'b1);
        check("load_ok_err", load_err, 1'b0);
        check("load_minsec", cur_minsec(), 16'h5959);
        step(1);
        check("load_time", cur_time(), 24'h125959);
        check("load_pm", pm, 1'b1);
        check("ack_one_cycle", load_ack, 1'b0);
        step(8);
        check("pre_tick_pulse", sec_pulse, 1'b0);
        step(1);
        check("tick_pulse", sec_pulse, 1'b1);
        check("tick_minsec", cur_minsec(), 16'h0000);
        step(1);
        check("tick_time", cur_time(), 24'h130000);

        // 12h display of 13:00.
        mode_12h_set = 1'b1;
        step(1);
        mode_12h_set = 1'b0;
        check("mode_on", mode_12h, 1'b1);
        check("mode_lag", {hrs_d, hrs_u}, 6'h13);
        step(1);
        check("disp_12h_13", {hrs_d, hrs_u}, 6'h01);
        check("disp_12h_pm", pm, 1'b1);
        mode_12h_set = 1'b1;
        step(1);
        mode_12h_set = 1'b0;
        step(1);
        check("disp_24h_back", {hrs_d, hrs_u}, 6'h13);

        // Rejected loads.
        load_valid = 1'b1; load_time = 24'h246000;
        step(1);
        check("rej1_err", load_err, 1'b1);
        check("rej1_ack", load_ack, 1'b0);
        load_time = 24'h1A0000;
        step(1);
        load_valid = 1'b0;
        check("rej2_err", load_err, 1'b1);
        check("rej2_ack", load_ack, 1'b0);
        check("rej_time", cur_time(), 24'h130000);
        step(1);
        check("rej_err_clear", load_err, 1'b0);

        // inc_min on the prescaler wrap cycle: tick is deferred one cycle.
        load_valid = 1'b1; load_time = 24'h105930;
        step(1);
        load_valid = 1'b0;
        check("load2_ack", load_ack, 1'b1);
        step(9);
        check("load2_time", cur_time(), 24'h105930);
        inc_min = 1'b1;
        step(1);
        inc_min = 1'b0;
        check("incmin_time", cur_time(), 24'h100000);
        check("incmin_nopulse", sec_pulse, 1'b0);
        step(1);
        check("pending_time", cur_time(), 24'h100001);
        check("pending_pulse", sec_pulse, 1'b1);
        inc_min = 1'b1; inc_hrs = 1'b1;
        step(1);
        inc_min = 1'b0; inc_hrs = 1'b0;
        check("inc_both_minsec", cur_minsec(), 16'h0100);
        step(1);
        check("inc_both_time", cur_time(), 24'h110100);

        // Pause for 35 clocks with prescaler at 3.
        run = 1'b0;
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            step(1);
            if (sec_pulse) pulses++;
        end
        check("pause_pulses", pulses, 0);
        check("pause_time", cur_time(), 24'h110100);
        run = 1'b1;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            waited++;
            if (sec_pulse) break;
        end
        check("resume_wait", waited, 7);
        check("resume_minsec", cur_minsec(), 16'h0101);

        // 12h sweep over boundary hours.
        mode_12h_set = 1'b1;
        step(1);
        mode_12h_set = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_time = sw_t[i];
            step(1);
            load_valid = 1'b0;
            step(1);
            check($sformatf("sweep_hrs_%0d", i), {hrs_d, hrs_u}, sw_h[i]);
            check($sformatf("sweep_pm_%0d", i), pm, sw_pm[i]);
        end
        inc_hrs = 1'b1;
        step(1);
        inc_hrs = 1'b0;
        step(1);
        check("inc_hrs_wrap", {hrs_d, hrs_u}, 6'h12);
        check("inc_hrs_wrap_pm", pm, 1'b0);
        check("inc_hrs_minsec", cur_minsec(), 16'h0000);

        // Asynchronous reset between clock edges.
        step(3);
        #2 reset = 1'b1;
        #1;
        check("async_time", cur_time(), 24'h235958);
        check("async_mode", mode_12h, 1'b0);
        check("async_pm", pm, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            waited++;
            if (sec_pulse) break;
        end
        check("post_reset_wait", waited, 10);
        check("post_reset_sec", cur_minsec(), 16'h5959);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
